// File: rtl/pipeline_controller.sv
// rtl/pipeline_controller.sv - hazard/stall controller: multi-cycle divide, load-use interlock, branch flush
// Produces fetch/decode/execute hold and flush controls plus a saturating stall-cycle counter.
module pipeline_controller #(
  parameter int DIV_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  OpCodeD,
  input  logic [3:0]  Rs1D,
  input  logic [3:0]  Rs2D,
  input  logic        UsesRs1D,
  input  logic        UsesRs2D,
  input  logic [3:0]  OpCodeE,
  input  logic [3:0]  RdE,
  input  logic        BranchTakenE,
  input  logic        StallClr,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        FlushD,
  output logic        FlushE,
  output logic        DivStart,
  output logic        DivBusy,
  output logic [15:0] StallCount
);

  localparam logic [3:0] OP_DIV   = 4'b1011;
  localparam logic [3:0] OP_LOAD0 = 4'b0100;
  localparam logic [3:0] OP_LOAD1 = 4'b0101;
  localparam logic [7:0] CNT_INIT = 8'(DIV_CYCLES - 1);

  typedef enum logic {RUN = 1'b0, DIV = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] stall_count_q, stall_count_d;

  logic div_hold;
  logic load_use;
  logic branch_flush;

  // Decode opcode shares the control-unit encoding but the hazard rules only need the register fields.
  logic unused_opcode_d;
  assign unused_opcode_d = ^OpCodeD;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RUN;
      cnt_q         <= 8'd0;
      stall_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stall_count_q <= stall_count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (OpCodeE == OP_DIV) begin
          state_d = DIV;
          cnt_d   = CNT_INIT;
        end
      end
      DIV: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // The Cnt=0 cycle of DIV releases execute so the divide result retires while DivBusy is still high.
  always_comb begin
    div_hold     = ((state_q == RUN) && (OpCodeE == OP_DIV)) ||
                   ((state_q == DIV) && (cnt_q != 8'd0));
    load_use     = ((OpCodeE == OP_LOAD0) || (OpCodeE == OP_LOAD1)) &&
                   ((UsesRs1D && (Rs1D == RdE)) || (UsesRs2D && (Rs2D == RdE)));
    branch_flush = BranchTakenE && !div_hold;

    StallE   = !rst && div_hold;
    StallF   = !rst && (div_hold || (load_use && !branch_flush));
    StallD   = StallF;
    FlushD   = !rst && branch_flush;
    FlushE   = !rst && !div_hold && (branch_flush || load_use);
    DivStart = !rst && (state_q == RUN) && (OpCodeE == OP_DIV);
    DivBusy  = !rst && (state_q == DIV);
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (StallClr) begin
      stall_count_d = 16'd0;
    end else if (StallF && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end
  end

  assign StallCount = stall_count_q;

endmodule

// File: tb/tb_pipeline_controller.sv
// tb/tb_pipeline_controller.sv - self-checking bench for pipeline_controller
// Directed vectors checked every cycle against a cycle-count model, plus literal spot checks.
module tb_pipeline_controller;

  localparam int DIVN = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  OpCodeD, Rs1D, Rs2D, OpCodeE, RdE;
  logic        UsesRs1D, UsesRs2D, BranchTakenE, StallClr;
  logic        StallF, StallD, StallE, FlushD, FlushE, DivStart, DivBusy;
  logic [15:0] StallCount;

  int vectors = 0;
  int errors  = 0;

  pipeline_controller #(.DIV_CYCLES(DIVN)) dut (
    .clk(clk), .rst(rst), .OpCodeD(OpCodeD), .Rs1D(Rs1D), .Rs2D(Rs2D),
    .UsesRs1D(UsesRs1D), .UsesRs2D(UsesRs2D), .OpCodeE(OpCodeE), .RdE(RdE),
    .BranchTakenE(BranchTakenE), .StallClr(StallClr), .StallF(StallF), .StallD(StallD),
    .StallE(StallE), .FlushD(FlushD), .FlushE(FlushE), .DivStart(DivStart),
    .DivBusy(DivBusy), .StallCount(StallCount)
  );

  always #5 clk = ~clk;

  // Model: busy_left counts remaining DivBusy cycles; 0 means no divide in flight.
  int busy_left;
  int exp_cnt;
  logic m_sf, m_se, m_fd, m_fe, m_start, m_busy;

  always @* begin
    logic starting, hold, lu, br;
    starting = (busy_left == 0) && (OpCodeE == 4'b1011);
    hold     = starting || (busy_left > 1);
    lu       = (OpCodeE == 4'b0100 || OpCodeE == 4'b0101) &&
               ((UsesRs1D && Rs1D == RdE) || (UsesRs2D && Rs2D == RdE));
    br       = BranchTakenE && !hold;
    m_se     = !rst && hold;
    m_sf     = !rst && (hold || (lu && !br));
    m_fd     = !rst && br;
    m_fe     = !rst && !hold && (br || lu);
    m_start  = !rst && starting;
    m_busy   = !rst && (busy_left > 0);
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_left = 0;
      exp_cnt   = 0;
    end else begin
      if (StallClr) exp_cnt = 0;
      else if (m_sf && exp_cnt < 65535) exp_cnt = exp_cnt + 1;
      if (busy_left == 0 && OpCodeE == 4'b1011) busy_left = DIVN;
      else if (busy_left > 0) busy_left = busy_left - 1;
    end
  end

  always @(negedge clk) begin
    vectors = vectors + 1;
    if ({StallF, StallD, StallE, FlushD, FlushE, DivStart, DivBusy} !==
        {m_sf, m_sf, m_se, m_fd, m_fe, m_start, m_busy} || StallCount !== 16'(exp_cnt)) begin
      errors = errors + 1;
      $display("FAIL cycle_cmp t=%0t got F%b D%b E%b fD%b fE%b st%b bz%b cnt=%h want F%b D%b E%b fD%b fE%b st%b bz%b cnt=%h",
               $time, StallF, StallD, StallE, FlushD, FlushE, DivStart, DivBusy, StallCount,
               m_sf, m_sf, m_se, m_fd, m_fe, m_start, m_busy, 16'(exp_cnt));
    end
  end

  task automatic check(input string name, input int act, input int exp);
    vectors = vectors + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    OpCodeE = 4'b0000; RdE = 4'd0; Rs1D = 4'd0; Rs2D = 4'd0;
    UsesRs1D = 1'b0; UsesRs2D = 1'b0; BranchTakenE = 1'b0; StallClr = 1'b0;
  endtask

  task automatic load_use(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] r1,
                          input logic [3:0] r2, input logic u1, input logic u2, input logic br);
    OpCodeE = op; RdE = rd; Rs1D = r1; Rs2D = r2; UsesRs1D = u1; UsesRs2D = u2; BranchTakenE = br;
  endtask

  int n_stall, n_start, n_busy;

  initial begin
    rst = 1'b1; OpCodeD = 4'b0000;
    idle();
    step(); step();
    check("reset_outputs", int'({StallF, StallE, FlushD, FlushE, DivStart, DivBusy}), 0);
    #1 rst = 1'b0;
    step();
    check("count_after_reset", int'(StallCount), 0);

    // Divide: hold opcode through the release cycle, then bubble.
    n_stall = 0; n_start = 0; n_busy = 0;
    OpCodeE = 4'b1011;
    for (int i = 0; i < DIVN + 1; i++) begin
      @(negedge clk);
      n_stall += int'(StallF && StallD && StallE);
      n_start += int'(DivStart);
      n_busy  += int'(DivBusy);
      step();
    end
    idle();
    check("div_stall_cycles", n_stall, 8);
    check("div_start_pulses", n_start, 1);
    check("div_busy_cycles", n_busy, 8);
    step();
    check("count_after_div", int'(StallCount), 8);
    check("model_cnt_after_div", exp_cnt, 8);

    load_use(4'b0100, 4'd3, 4'd0, 4'd3, 1'b0, 1'b1, 1'b0);
    #1 check("lu_rs2_stall", int'({StallF, StallD, FlushE}), 7);
    step();
    load_use(4'b0100, 4'd3, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0);
    #1 check("lu_unused_nostall", int'({StallF, StallD, FlushE}), 0);
    step();
    load_use(4'b0101, 4'd9, 4'd9, 4'd1, 1'b1, 1'b0, 1'b0); step();
    load_use(4'b0101, 4'd9, 4'd8, 4'd1, 1'b1, 1'b1, 1'b0); step();
    load_use(4'b0001, 4'd2, 4'd2, 4'd2, 1'b1, 1'b1, 1'b0); step();
    load_use(4'b0100, 4'd0, 4'd0, 4'd5, 1'b1, 1'b0, 1'b0); step();
    check("count_after_lu", int'(StallCount), 11);

    load_use(4'b0100, 4'd3, 4'd0, 4'd3, 1'b0, 1'b1, 1'b1);
    #1 check("branch_over_lu", int'({FlushD, FlushE, StallF}), 6);
    step();
    idle();
    check("count_branch_unchanged", int'(StallCount), 11);
    step();

    // Branch asserted while a divide holds execute must be ignored.
    OpCodeE = 4'b1011; BranchTakenE = 1'b1;
    #1 check("branch_ignored_in_div", int'({FlushD, FlushE, StallE}), 1);
    step(); step();
    BranchTakenE = 1'b0;
    #1 rst = 1'b1;
    #1 check("reset_midway_outputs", int'({StallF, StallD, StallE, FlushD, FlushE, DivStart, DivBusy}), 0);
    check("reset_midway_count", int'(StallCount), 0);
    step();
    rst = 1'b0;
    #1 check("fresh_div_start", int'(DivStart), 1);
    for (int i = 0; i < DIVN; i++) step();
    idle();
    step();

    StallClr = 1'b1; step(); StallClr = 1'b0;
    load_use(4'b0100, 4'd7, 4'd7, 4'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 65534; i++) step();
    check("count_fffe", int'(StallCount), 65534);
    for (int i = 0; i < 3; i++) step();
    check("count_saturated", int'(StallCount), 65535);
    StallClr = 1'b1; step();
    check("clr_over_stall", int'(StallCount), 0);
    idle();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_controller.md
PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

Interface
REQ-001 Parameter DIV_CYCLES, default 8, total stall cycles for a divide; legal range 2..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 OpCodeD  input  4  opcode of instruction in decode; same encoding as the control unit.
REQ-005 Rs1D, Rs2D  input  4 each  source register indices of decode instruction.
REQ-006 UsesRs1D, UsesRs2D  input  1 each  decode instruction reads Rs1D/Rs2D.
REQ-007 OpCodeE  input  4  opcode of instruction in execute; 4'b0000 = NOP/bubble.
REQ-008 RdE  input  4  destination register index of execute instruction.
REQ-009 BranchTakenE  input  1  branch in execute resolved taken this cycle.
REQ-010 StallClr  input  1  synchronous clear of StallCount.
REQ-011 StallF, StallD, StallE  output  1 each  hold fetch / decode / execute registers.
REQ-012 FlushD, FlushE  output  1 each  load bubble into decode / execute register.
REQ-013 DivStart  output  1  one-cycle pulse starting the divider.
REQ-014 DivBusy  output  1  divide in progress (state DIV).
REQ-015 StallCount  output  16  count of cycles with StallF=1, saturating.

Function
REQ-016 Load opcodes: 4'b0100, 4'b0101; divide: 4'b1011; branches: 4'b0001-4'b0011; register 0 is not special.
REQ-017 FSM states: RUN, DIV; 8-bit down-counter Cnt.
REQ-018 RUN with OpCodeE=1011: StallF=StallD=StallE=1, DivStart=1; next state DIV, Cnt <= DIV_CYCLES-1.
REQ-019 DIV with Cnt!=0: StallF=StallD=StallE=1, DivBusy=1, Cnt decrements.
REQ-020 DIV with Cnt=0: DivBusy=1, no stalls from divide; next state RUN, so a divide stalls exactly DIV_CYCLES cycles.
REQ-021 DivStart never asserted in DIV; same divide is not restarted.
REQ-022 Load-use: OpCodeE is load and ((UsesRs1D and Rs1D=RdE) or (UsesRs2D and Rs2D=RdE)) -> StallF=StallD=1, FlushE=1 for that cycle.
REQ-023 BranchTakenE=1 -> FlushD=FlushE=1, StallF=StallD=0; overrides load-use.
REQ-024 While StallE=1, FlushE=0 and FlushD=0; load-use is evaluated again once the divide releases.
REQ-025 BranchTakenE with divide in execute is illegal; branch rule is ignored while StallE=1.
REQ-026 Stall/flush/DivStart/DivBusy outputs are combinational from inputs and state; no added latency.
REQ-027 StallCount increments on each edge where StallF=1, holds at 16'hFFFF; StallClr=1 loads 0 and takes priority over increment.

Reset
REQ-028 rst=1 asynchronously forces state RUN, Cnt=0, StallCount=0.
REQ-029 While rst=1 all 1-bit outputs are 0.
REQ-030 Reset during DIV abandons the divide; after release, a divide still in execute starts fresh from RUN.

Verification
REQ-031 OpCodeE=1011, DIV_CYCLES=8 -> DivStart for 1 cycle, StallF/D/E high 8 consecutive cycles, DivBusy high 8 cycles, then RUN.
REQ-032 OpCodeE=0100, RdE=3, Rs2D=3, UsesRs2D=1 -> StallF=StallD=FlushE=1 one cycle; with UsesRs2D=0 -> no stall.
REQ-033 BranchTakenE=1 together with load-use hit -> FlushD=FlushE=1, StallF=0, StallCount unchanged.
REQ-034 rst pulsed at 3rd stall cycle of a divide -> outputs 0 immediately, state RUN, StallCount=0.
REQ-035 Force StallCount to 16'hFFFE, hold 3 stall cycles -> 16'hFFFF held; StallClr=1 with StallF=1 -> 0.
